slave_axi4lite_regs: RTL and testbench
======================================

SLAVE_AXI4LITE_REGS -- requirements
Module: slave_axi4lite_regs

Interface
REQ-001 SHALL have parameter C_S_AXI_DATA_WIDTH, default 32, the data bus width.
REQ-002 SHALL have parameter C_S_AXI_ADDR_WIDTH, default 4, the byte address width.
REQ-003 SHALL have port S_AXI_ACLK  in  1  the single clock; all logic is on its rising edge.
REQ-004 SHALL have port S_AXI_ARESETN  in  1  asynchronous active-low reset.
REQ-005 SHALL have port S_AXI_AWADDR  in  C_S_AXI_ADDR_WIDTH  write address.
REQ-006 SHALL have port S_AXI_AWPROT  in  3  write protection; accepted and ignored.
REQ-007 SHALL have port S_AXI_AWVALID  in  1  write address valid.
REQ-008 SHALL have port S_AXI_AWREADY  out  1  write address ready.
REQ-009 SHALL have port S_AXI_WDATA  in  C_S_AXI_DATA_WIDTH  write data.
REQ-010 SHALL have port S_AXI_WSTRB  in  C_S_AXI_DATA_WIDTH/8  byte strobes; present only with the macro in REQ-031.
REQ-011 SHALL have port S_AXI_WVALID  in  1  write data valid.
REQ-012 SHALL have port S_AXI_WREADY  out  1  write data ready.
REQ-013 SHALL have port S_AXI_BRESP  out  2  write response; constant 2'b00 (OKAY).
REQ-014 SHALL have port S_AXI_BVALID  out  1  write response valid.
REQ-015 SHALL have port S_AXI_BREADY  in  1  write response ready.
REQ-016 SHALL have port S_AXI_ARADDR  in  C_S_AXI_ADDR_WIDTH  read address.
REQ-017 SHALL have port S_AXI_ARPROT  in  3  read protection; accepted and ignored.
REQ-018 SHALL have port S_AXI_ARVALID  in  1  read address valid.
REQ-019 SHALL have port S_AXI_ARREADY  out  1  read address ready.
REQ-020 SHALL have port S_AXI_RDATA  out  C_S_AXI_DATA_WIDTH  read data, registered.
REQ-021 SHALL have port S_AXI_RRESP  out  2  read response; constant 2'b00 (OKAY).
REQ-022 SHALL have port S_AXI_RVALID  out  1  read data valid.
REQ-023 SHALL have port S_AXI_RREADY  in  1  read data ready.

Function
REQ-024 SHALL implement four C_S_AXI_DATA_WIDTH registers REG0..REG3 selected by address bits [3:2]; bits [1:0] ignored; every address answers OKAY.
REQ-025 SHALL derive AWREADY = !aw_held && !BVALID and WREADY = !w_held && !BVALID from internal state only, never from any VALID input.
REQ-026 SHALL latch AWADDR and set aw_held on the AW handshake edge; SHALL latch WDATA (and WSTRB) and set w_held on the W handshake edge; AW and W may arrive in either order or the same cycle.
REQ-027 SHALL commit the write on the first edge where aw_held and w_held are both 1, clear both flags and set BVALID on that edge (BVALID one cycle after the later handshake).
REQ-028 SHALL hold BVALID until the edge where BVALID && BREADY, then clear it; at most one write is outstanding; BREADY held high before BVALID completes the response on the edge BVALID rises plus one.
REQ-029 SHALL drive ARREADY = !RVALID; on the AR handshake edge SHALL load RDATA with the selected register and set RVALID; RVALID and RDATA SHALL hold stable until the RVALID && RREADY edge, which clears RVALID.
REQ-030 SHALL, when a read handshake and a write commit to the same register share an edge, return the pre-write value; read and write channels are otherwise fully independent.

Configuration
REQ-031 SHALL, with macro SLAVE_AXI4LITE_WSTRB_EN defined, include S_AXI_WSTRB and update only bytes whose strobe is 1; without it, omit the port and write all bytes on every commit.

Reset
REQ-032 SHALL, while S_AXI_ARESETN is 0, asynchronously force REG0..REG3, RDATA, aw_held, w_held, BVALID and RVALID to 0, giving AWREADY=1, WREADY=1, ARREADY=1, BRESP=RRESP=0.
REQ-033 SHALL abandon any partially held write or pending response on reset mid-operation, with no register update; operation resumes on the first edge after release.

Verification
REQ-034 SHALL cover: AW and W same cycle, addr 0x4, data 0xDEADBEEF -> BVALID next cycle, then read 0x4 returns 0xDEADBEEF, RRESP 0.
REQ-035 SHALL cover: W three cycles before AW, addr 0xC, data 0x12345678 -> WREADY low after W handshake, BVALID one cycle after AW handshake, REG3 = 0x12345678.
REQ-036 SHALL cover: BREADY held low 5 cycles after BVALID -> BVALID stays 1, AWREADY/WREADY stay 0, next write blocked until B handshake.
REQ-037 SHALL cover: with SLAVE_AXI4LITE_WSTRB_EN, REG1 = 0xFFFFFFFF, write 0x00000000 with WSTRB 4'b0101 -> read returns 0xFF00FF00.
REQ-038 SHALL cover: read of REG2 (0xAAAA5555) same edge as write commit of 0x11111111 to REG2 -> RDATA 0xAAAA5555, later read 0x11111111.
REQ-039 SHALL cover: reset asserted with aw_held=1 and RVALID=1 -> all outputs at reset values immediately, REG0..REG3 read back 0.

Source files
------------

// File: rtl/slave_axi4lite_regs.sv
// AXI4-Lite slave with four data-width registers at address bits [3:2].
// Define SLAVE_AXI4LITE_WSTRB_EN to add S_AXI_WSTRB and per-byte write masking.
module slave_axi4lite_regs #(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 4
) (
    input  logic                            S_AXI_ACLK,
    input  logic                            S_AXI_ARESETN,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
    input  logic [2:0]                      S_AXI_AWPROT,
    input  logic                            S_AXI_AWVALID,
    output logic                            S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
`ifdef SLAVE_AXI4LITE_WSTRB_EN
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
`endif
    input  logic                            S_AXI_WVALID,
    output logic                            S_AXI_WREADY,
    output logic [1:0]                      S_AXI_BRESP,
    output logic                            S_AXI_BVALID,
    input  logic                            S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
    input  logic [2:0]                      S_AXI_ARPROT,
    input  logic                            S_AXI_ARVALID,
    output logic                            S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
    output logic [1:0]                      S_AXI_RRESP,
    output logic                            S_AXI_RVALID,
    input  logic                            S_AXI_RREADY
);
    localparam int NBYTES = C_S_AXI_DATA_WIDTH / 8;

    logic                          aw_held_reg;
    logic                          w_held_reg;
    logic                          bvalid_reg;
    logic                          rvalid_reg;
    logic [1:0]                    waddr_reg;
    logic [C_S_AXI_DATA_WIDTH-1:0] wdata_reg;
    logic [C_S_AXI_DATA_WIDTH-1:0] rdata_reg;
    logic [C_S_AXI_DATA_WIDTH-1:0] regs_reg [4];
    logic [C_S_AXI_DATA_WIDTH-1:0] wmask;
`ifdef SLAVE_AXI4LITE_WSTRB_EN
    logic [NBYTES-1:0]             wstrb_reg;
`endif

    logic aw_hs;
    logic w_hs;
    logic ar_hs;
    logic commit;

    // Ready terms depend only on internal state so a master may wait on READY.
    assign S_AXI_AWREADY = !aw_held_reg && !bvalid_reg;
    assign S_AXI_WREADY  = !w_held_reg && !bvalid_reg;
    assign S_AXI_ARREADY = !rvalid_reg;
    assign S_AXI_BVALID  = bvalid_reg;
    assign S_AXI_RVALID  = rvalid_reg;
    assign S_AXI_RDATA   = rdata_reg;
    assign S_AXI_BRESP   = 2'b00;
    assign S_AXI_RRESP   = 2'b00;

    assign aw_hs  = S_AXI_AWVALID && S_AXI_AWREADY;
    assign w_hs   = S_AXI_WVALID && S_AXI_WREADY;
    assign ar_hs  = S_AXI_ARVALID && S_AXI_ARREADY;
    assign commit = aw_held_reg && w_held_reg;

    genvar gi;
    generate
        for (gi = 0; gi < NBYTES; gi++) begin : g_mask
`ifdef SLAVE_AXI4LITE_WSTRB_EN
            assign wmask[gi*8 +: 8] = {8{wstrb_reg[gi]}};
`else
            assign wmask[gi*8 +: 8] = 8'hFF;
`endif
        end
    endgenerate

    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            aw_held_reg <= 1'b0;
            w_held_reg  <= 1'b0;
            bvalid_reg  <= 1'b0;
            waddr_reg   <= '0;
            wdata_reg   <= '0;
`ifdef SLAVE_AXI4LITE_WSTRB_EN
            wstrb_reg   <= '0;
`endif
        end else begin
            if (aw_hs) begin
                aw_held_reg <= 1'b1;
                waddr_reg   <= S_AXI_AWADDR[3:2];
            end
            if (w_hs) begin
                w_held_reg <= 1'b1;
                wdata_reg  <= S_AXI_WDATA;
`ifdef SLAVE_AXI4LITE_WSTRB_EN
                wstrb_reg  <= S_AXI_WSTRB;
`endif
            end
            // Handshakes cannot coincide with commit: both READYs are low then.
            if (commit) begin
                aw_held_reg <= 1'b0;
                w_held_reg  <= 1'b0;
                bvalid_reg  <= 1'b1;
            end else if (bvalid_reg && S_AXI_BREADY) begin
                bvalid_reg <= 1'b0;
            end
        end
    end

    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            for (int i = 0; i < 4; i++) begin
                regs_reg[i] <= '0;
            end
        end else if (commit) begin
            regs_reg[waddr_reg] <= (regs_reg[waddr_reg] & ~wmask) | (wdata_reg & wmask);
        end
    end

    // A read sharing an edge with a commit samples the old register value.
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            rvalid_reg <= 1'b0;
            rdata_reg  <= '0;
        end else if (ar_hs) begin
            rvalid_reg <= 1'b1;
            rdata_reg  <= regs_reg[S_AXI_ARADDR[3:2]];
        end else if (rvalid_reg && S_AXI_RREADY) begin
            rvalid_reg <= 1'b0;
        end
    end

    logic unused_ok;
    assign unused_ok = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};
endmodule

// File: tb/tb_slave_axi4lite_regs.sv
// Directed bench for slave_axi4lite_regs; define SLAVE_AXI4LITE_WSTRB_EN to
// also exercise the byte-strobe build.
module tb_slave_axi4lite_regs;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  awaddr = '0;
    logic [2:0]  awprot = '0;
    logic        awvalid = 1'b0;
    logic        awready;
    logic [31:0] wdata = '0;
`ifdef SLAVE_AXI4LITE_WSTRB_EN
    logic [3:0]  wstrb = 4'hF;
`endif
    logic        wvalid = 1'b0;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready = 1'b0;
    logic [3:0]  araddr = '0;
    logic [2:0]  arprot = '0;
    logic        arvalid = 1'b0;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready = 1'b0;

    int n_vec = 0;
    int n_miss = 0;

    always #5 clk = ~clk;

    slave_axi4lite_regs #(.C_S_AXI_DATA_WIDTH(32), .C_S_AXI_ADDR_WIDTH(4)) dut (
        .S_AXI_ACLK    (clk),
        .S_AXI_ARESETN (rst_n),
        .S_AXI_AWADDR  (awaddr),
        .S_AXI_AWPROT  (awprot),
        .S_AXI_AWVALID (awvalid),
        .S_AXI_AWREADY (awready),
        .S_AXI_WDATA   (wdata),
`ifdef SLAVE_AXI4LITE_WSTRB_EN
        .S_AXI_WSTRB   (wstrb),
`endif
        .S_AXI_WVALID  (wvalid),
        .S_AXI_WREADY  (wready),
        .S_AXI_BRESP   (bresp),
        .S_AXI_BVALID  (bvalid),
        .S_AXI_BREADY  (bready),
        .S_AXI_ARADDR  (araddr),
        .S_AXI_ARPROT  (arprot),
        .S_AXI_ARVALID (arvalid),
        .S_AXI_ARREADY (arready),
        .S_AXI_RDATA   (rdata),
        .S_AXI_RRESP   (rresp),
        .S_AXI_RVALID  (rvalid),
        .S_AXI_RREADY  (rready)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end else begin
            $display("ok   %s: %08h", tag, got);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Same-cycle AW+W write with BREADY held high; full response completes.
    task automatic do_write(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s);
        awaddr = a; wdata = d; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
`ifdef SLAVE_AXI4LITE_WSTRB_EN
        wstrb = s;
`else
        if (s == 4'h0) $display("note: strobe ignored in this build");
`endif
        tick;
        awvalid = 1'b0; wvalid = 1'b0;
        tick;
        check_val("wr_bvalid", {31'b0, bvalid}, 32'd1);
        tick;
        check_val("wr_bdone", {31'b0, bvalid}, 32'd0);
        bready = 1'b0;
`ifdef SLAVE_AXI4LITE_WSTRB_EN
        wstrb = 4'hF;
`endif
    endtask

    task automatic do_read(input logic [3:0] a, input logic [31:0] exp, input string tag);
        check_val("rd_arready", {31'b0, arready}, 32'd1);
        araddr = a; arvalid = 1'b1;
        tick;
        arvalid = 1'b0;
        check_val("rd_rvalid", {31'b0, rvalid}, 32'd1);
        check_val(tag, rdata, exp);
        check_val("rd_rresp", {30'b0, rresp}, 32'd0);
        rready = 1'b1;
        tick;
        check_val("rd_rdone", {31'b0, rvalid}, 32'd0);
        rready = 1'b0;
    endtask

    initial begin
        // Reset state
        #12;
        check_val("rst_awready", {31'b0, awready}, 32'd1);
        check_val("rst_wready", {31'b0, wready}, 32'd1);
        check_val("rst_arready", {31'b0, arready}, 32'd1);
        check_val("rst_bvalid", {31'b0, bvalid}, 32'd0);
        check_val("rst_rvalid", {31'b0, rvalid}, 32'd0);
        check_val("rst_resp", {28'b0, bresp, rresp}, 32'd0);
        check_val("rst_rdata", rdata, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick;

        // AW and W together, BREADY low: BVALID one cycle after handshake
        awaddr = 4'h4; wdata = 32'hDEADBEEF; awvalid = 1'b1; wvalid = 1'b1;
        tick;
        awvalid = 1'b0; wvalid = 1'b0;
        check_val("same_bvalid0", {31'b0, bvalid}, 32'd0);
        check_val("same_awready", {31'b0, awready}, 32'd0);
        tick;
        check_val("same_bvalid1", {31'b0, bvalid}, 32'd1);
        check_val("same_bresp", {30'b0, bresp}, 32'd0);
        bready = 1'b1;
        tick;
        check_val("same_bdone", {31'b0, bvalid}, 32'd0);
        bready = 1'b0;
        do_read(4'h4, 32'hDEADBEEF, "same_rd");

        // W three cycles ahead of AW
        wdata = 32'h12345678; wvalid = 1'b1;
        tick;
        wvalid = 1'b0;
        check_val("wfirst_wready", {31'b0, wready}, 32'd0);
        check_val("wfirst_awready", {31'b0, awready}, 32'd1);
        tick;
        tick;
        check_val("wfirst_nobv", {31'b0, bvalid}, 32'd0);
        awaddr = 4'hC; awvalid = 1'b1;
        tick;
        awvalid = 1'b0;
        check_val("wfirst_bv0", {31'b0, bvalid}, 32'd0);
        tick;
        check_val("wfirst_bv1", {31'b0, bvalid}, 32'd1);
        bready = 1'b1;
        tick;
        bready = 1'b0;
        do_read(4'hC, 32'h12345678, "wfirst_rd");

        // BREADY stalled five cycles: channel blocked
        awaddr = 4'h0; wdata = 32'h0BADF00D; awvalid = 1'b1; wvalid = 1'b1;
        tick;
        awaddr = 4'h8; wdata = 32'h00000055;
        tick;
        for (int i = 0; i < 5; i++) begin
            check_val("stall_bvalid", {31'b0, bvalid}, 32'd1);
            check_val("stall_ready", {30'b0, awready, wready}, 32'd0);
            tick;
        end
        check_val("stall_bvalid", {31'b0, bvalid}, 32'd1);
        bready = 1'b1;
        tick;
        check_val("stall_release", {31'b0, bvalid}, 32'd0);
        check_val("stall_ready_up", {30'b0, awready, wready}, 32'd3);
        tick;
        awvalid = 1'b0; wvalid = 1'b0;
        tick;
        check_val("stall_bv2", {31'b0, bvalid}, 32'd1);
        tick;
        bready = 1'b0;
        do_read(4'h0, 32'h0BADF00D, "stall_rd0");
        do_read(4'h8, 32'h00000055, "stall_rd2");

        // Low address bits ignored
        do_write(4'hF, 32'hCAFEF00D, 4'hF);
        do_read(4'hC, 32'hCAFEF00D, "alias_rd");

        // Read and commit on the same edge to REG2
        do_write(4'h8, 32'hAAAA5555, 4'hF);
        awaddr = 4'h8; wdata = 32'h11111111; awvalid = 1'b1; wvalid = 1'b1;
        tick;
        awvalid = 1'b0; wvalid = 1'b0;
        araddr = 4'h8; arvalid = 1'b1;
        tick;
        arvalid = 1'b0;
        check_val("race_bvalid", {31'b0, bvalid}, 32'd1);
        check_val("race_rvalid", {31'b0, rvalid}, 32'd1);
        check_val("race_rdata", rdata, 32'hAAAA5555);
        rready = 1'b1; bready = 1'b1;
        tick;
        rready = 1'b0; bready = 1'b0;
        do_read(4'h8, 32'h11111111, "race_after");

`ifdef SLAVE_AXI4LITE_WSTRB_EN
        // Byte strobes
        do_write(4'h4, 32'hFFFFFFFF, 4'hF);
        do_write(4'h4, 32'h00000000, 4'b0101);
        do_read(4'h4, 32'hFF00FF00, "strb_rd");
`endif

        // Reset with AW held and RVALID pending
        awaddr = 4'h0; awvalid = 1'b1;
        araddr = 4'h4; arvalid = 1'b1;
        tick;
        awvalid = 1'b0; arvalid = 1'b0;
        check_val("pre_awready", {31'b0, awready}, 32'd0);
        check_val("pre_rvalid", {31'b0, rvalid}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check_val("mrst_ready", {29'b0, awready, wready, arready}, 32'd7);
        check_val("mrst_valid", {30'b0, bvalid, rvalid}, 32'd0);
        check_val("mrst_rdata", rdata, 32'd0);
        tick;
        tick;
        rst_n = 1'b1;
        tick;
        check_val("post_awready", {31'b0, awready}, 32'd1);
        do_read(4'h0, 32'd0, "post_reg0");
        do_read(4'h4, 32'd0, "post_reg1");
        do_read(4'h8, 32'd0, "post_reg2");
        do_read(4'hC, 32'd0, "post_reg3");
        // A lone W after reset must wait for a fresh AW
        wdata = 32'h00000077; wvalid = 1'b1;
        tick;
        wvalid = 1'b0;
        tick;
        check_val("post_wonly", {31'b0, bvalid}, 32'd0);
        awaddr = 4'h0; awvalid = 1'b1;
        tick;
        awvalid = 1'b0;
        tick;
        check_val("post_bvalid", {31'b0, bvalid}, 32'd1);
        bready = 1'b1;
        tick;
        bready = 1'b0;
        do_read(4'h0, 32'h00000077, "post_wr");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
